tmr_scrub_ctrl: RTL and testbench

Periodic scrub scheduler for banks of self-correcting TMR registers. It walks NGROUPS register groups and gives each a one-cycle refresh (load) strobe so the voted value is rewritten into all three replicas. It samples each group's voter error flag before and after the refresh, and keeps error statistics for slow-control readout. Sits beside the triplicated register banks; its outputs drive the groups' load-force inputs.

---
 rtl/tmr_scrub_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_tmr_scrub_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_scrub_ctrl.sv
// Periodic scrub scheduler for self-correcting TMR register groups.
// Strobes one group at a time and keeps sticky error statistics around each refresh.
module tmr_scrub_ctrl #(
    parameter int NGROUPS   = 8,
    parameter int PERIOD    = 256,
    parameter int MAX_DEFER = 4,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               forceSweep,
    input  logic               clear,
    input  logic [NGROUPS-1:0] busy,
    input  logic [NGROUPS-1:0] tmrErr,
    output logic [NGROUPS-1:0] refresh,
    output logic               sweepDone,
    output logic [CNT_W-1:0]   errCount,
    output logic [NGROUPS-1:0] errMask,
    output logic [NGROUPS-1:0] persistMask,
    output logic [NGROUPS-1:0] skipMask
);

    localparam int IDX_W  = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam int WAIT_W = $clog2(PERIOD);
    localparam int DEF_W  = $clog2(MAX_DEFER + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NGROUPS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(PERIOD - 1);
    localparam logic [DEF_W-1:0]  DEFER_MAX = DEF_W'(MAX_DEFER);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SCRUB,
        CHECK,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [DEF_W-1:0]    defer_q, defer_d;
    logic                check_sample_q, check_sample_d;
    logic [NGROUPS-1:0]  refresh_q, refresh_d;
    logic                sweep_done_q, sweep_done_d;
    logic [CNT_W-1:0]    err_count_q, err_count_d;
    logic [NGROUPS-1:0]  err_mask_q, err_mask_d;
    logic [NGROUPS-1:0]  persist_mask_q, persist_mask_d;
    logic [NGROUPS-1:0]  skip_mask_q, skip_mask_d;

    logic cur_busy;
    logic cur_err;
    logic group_done;

    assign cur_busy = busy[idx_q];
    assign cur_err  = tmrErr[idx_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            wait_cnt_q     <= '0;
            defer_q        <= '0;
            check_sample_q <= 1'b0;
            refresh_q      <= '0;
            sweep_done_q   <= 1'b0;
            err_count_q    <= '0;
            err_mask_q     <= '0;
            persist_mask_q <= '0;
            skip_mask_q    <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            wait_cnt_q     <= wait_cnt_d;
            defer_q        <= defer_d;
            check_sample_q <= check_sample_d;
            refresh_q      <= refresh_d;
            sweep_done_q   <= sweep_done_d;
            err_count_q    <= err_count_d;
            err_mask_q     <= err_mask_d;
            persist_mask_q <= persist_mask_d;
            skip_mask_q    <= skip_mask_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        wait_cnt_d     = wait_cnt_q;
        defer_d        = defer_q;
        check_sample_d = 1'b0;
        refresh_d      = '0;
        sweep_done_d   = 1'b0;
        group_done     = 1'b0;

        // clear acts first so a same-cycle update lands on top of it
        err_count_d    = clear ? '0 : err_count_q;
        err_mask_d     = clear ? '0 : err_mask_q;
        persist_mask_d = clear ? '0 : persist_mask_q;
        skip_mask_d    = clear ? '0 : skip_mask_q;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d    = WAIT;
                    wait_cnt_d = WAIT_LOAD;
                end
            end
            WAIT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (wait_cnt_q == '0 || forceSweep) begin
                    state_d = SCRUB;
                    idx_d   = '0;
                    defer_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            SCRUB: begin
                if (!cur_busy) begin
                    if (cur_err) begin
                        err_mask_d[idx_q] = 1'b1;
                        if (err_count_d != CNT_MAX) begin
                            err_count_d = err_count_d + 1'b1;
                        end
                    end
                    refresh_d[idx_q] = 1'b1;
                    state_d          = CHECK;
                end else if (defer_q != DEFER_MAX) begin
                    defer_d = defer_q + 1'b1;
                end else begin
                    skip_mask_d[idx_q] = 1'b1;
                    group_done         = 1'b1;
                end
            end
            CHECK: begin
                // first cycle carries the strobe; the voters settle before the second
                if (!check_sample_q) begin
                    check_sample_d = 1'b1;
                end else begin
                    if (cur_err) begin
                        persist_mask_d[idx_q] = 1'b1;
                    end
                    group_done = 1'b1;
                end
            end
            DONE: begin
                state_d    = enable ? WAIT : IDLE;
                wait_cnt_d = WAIT_LOAD;
                idx_d      = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // a dropped enable lets the current group finish, then ends the sweep
        if (group_done) begin
            defer_d = '0;
            if (idx_q == LAST_IDX || !enable) begin
                state_d      = DONE;
                sweep_done_d = 1'b1;
            end else begin
                state_d = SCRUB;
                idx_d   = idx_q + 1'b1;
            end
        end
    end

    assign refresh     = refresh_q;
    assign sweepDone   = sweep_done_q;
    assign errCount    = err_count_q;
    assign errMask     = err_mask_q;
    assign persistMask = persist_mask_q;
    assign skipMask    = skip_mask_q;

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Bench for tmr_scrub_ctrl: directed scenarios with literal expectations, then random traffic,
// all checked each cycle against a sequential behavioural model of the scrub schedule.
module tb_tmr_scrub_ctrl;

    localparam int NG     = 8;
    localparam int PER    = 12;
    localparam int MAXD   = 4;
    localparam int CW     = 4;
    localparam int CMAX   = (1 << CW) - 1;
    localparam int BUDGET = 2 * PER + 60;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          forceSweep = 1'b0;
    logic          clear = 1'b0;
    logic [NG-1:0] busy = '0;
    logic [NG-1:0] tmrErr = '0;
    logic [NG-1:0] refresh;
    logic          sweepDone;
    logic [CW-1:0] errCount;
    logic [NG-1:0] errMask;
    logic [NG-1:0] persistMask;
    logic [NG-1:0] skipMask;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    tmr_scrub_ctrl #(
        .NGROUPS  (NG),
        .PERIOD   (PER),
        .MAX_DEFER(MAXD),
        .CNT_W    (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .forceSweep (forceSweep),
        .clear      (clear),
        .busy       (busy),
        .tmrErr     (tmrErr),
        .refresh    (refresh),
        .sweepDone  (sweepDone),
        .errCount   (errCount),
        .errMask    (errMask),
        .persistMask(persistMask),
        .skipMask   (skipMask)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected outputs, valid from each rising edge until the next one
    logic [NG-1:0] m_refresh = '0;
    logic [NG-1:0] m_err = '0;
    logic [NG-1:0] m_persist = '0;
    logic [NG-1:0] m_skip = '0;
    logic          m_done = 1'b0;
    int            m_cnt = 0;
    bit            m_rst = 1'b0;

    // One model clock edge: pulses drop, reset and clear take effect before any update
    task automatic modelEdge();
        @(posedge clk);
        m_refresh = '0;
        m_done    = 1'b0;
        m_rst     = rst;
        if (rst || clear) begin
            m_cnt     = 0;
            m_err     = '0;
            m_persist = '0;
            m_skip    = '0;
        end
    endtask

    // Script of the schedule from idle; returns whenever the block falls back to idle
    task automatic modelSession();
        int wt;
        int defer;
        bit go;
        do begin
            modelEdge();
            if (m_rst) return;
        end while (!enable);
        forever begin
            wt = PER - 1;
            go = 1'b0;
            while (!go) begin
                modelEdge();
                if (m_rst || !enable) return;
                if (wt == 0 || forceSweep) go = 1'b1;
                else wt--;
            end
            for (int g = 0; g < NG; g++) begin
                defer = 0;
                forever begin
                    modelEdge();
                    if (m_rst) return;
                    if (!busy[g]) begin
                        if (tmrErr[g]) begin
                            m_err[g] = 1'b1;
                            if (m_cnt < CMAX) m_cnt++;
                        end
                        m_refresh[g] = 1'b1;
                        modelEdge();
                        if (m_rst) return;
                        modelEdge();
                        if (m_rst) return;
                        if (tmrErr[g]) m_persist[g] = 1'b1;
                        break;
                    end
                    if (defer < MAXD) defer++;
                    else begin
                        m_skip[g] = 1'b1;
                        break;
                    end
                end
                if (!enable || g == NG - 1) break;
            end
            m_done = 1'b1;
            modelEdge();
            if (m_rst || !enable) return;
        end
    endtask

    always begin
        modelSession();
    end

    always @(posedge clk) begin
        #1;
        checkOutput("refresh", refresh, m_refresh);
        checkOutput("sweepDone", sweepDone, m_done);
        checkOutput("errCount", errCount, m_cnt);
        checkOutput("errMask", errMask, m_err);
        checkOutput("persistMask", persistMask, m_persist);
        checkOutput("skipMask", skipMask, m_skip);
    end

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic waitRefresh(input int g, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (refresh[g]) begin
                at = cyc;
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("[TB] FAIL wait_refresh%0d: no strobe within %0d cycles, required one", g, budget);
    endtask

    task automatic waitDone(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (sweepDone) begin
                at = cyc;
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("[TB] FAIL wait_sweepDone: no pulse within %0d cycles, required one", budget);
    endtask

    // Called just after refresh[g-1] is seen; holds busy[g] over 'hold' scrub decisions
    task automatic busyProbe(input int g, input int hold, output logic [NG-1:0] vec, output int at);
        int found;
        found = 0;
        vec   = '0;
        at    = -1;
        nextCycle();
        nextCycle();
        busy[g] = 1'b1;
        for (int i = 0; i < hold + 10; i++) begin
            @(posedge clk);
            #1;
            if (found == 0 && refresh != '0) begin
                found = 1;
                vec   = refresh;
                at    = cyc;
            end
            if (i == hold - 1) busy[g] = 1'b0;
        end
    endtask

    logic hot_busy_on = 1'b0;
    int   hot_busy_grp = 0;

    task automatic applyStimulus();
        nextCycle();
        if ($urandom_range(0, 99) < 3) enable = ~enable;
        forceSweep = ($urandom_range(0, 99) < 5);
        clear      = ($urandom_range(0, 99) < 3);
        rst        = ($urandom_range(0, 999) < 4);
        if ($urandom_range(0, 99) < 2) begin
            hot_busy_on  = ~hot_busy_on;
            hot_busy_grp = $urandom_range(0, NG - 1);
        end
        busy = NG'($urandom) & NG'($urandom) & NG'($urandom);
        if (hot_busy_on) busy[hot_busy_grp] = 1'b1;
        tmrErr = NG'($urandom) & NG'($urandom) & NG'($urandom) & NG'($urandom);
    endtask

    initial begin
        int c0;
        int at;
        int r0;
        int r1;
        int rprev;
        logic [NG-1:0] vec;

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        nextCycle();
        checkOutput("reset_refresh", refresh, 0);
        checkOutput("reset_sweepDone", sweepDone, 0);
        checkOutput("reset_errCount", errCount, 0);
        checkOutput("reset_masks", {errMask, persistMask, skipMask}, 0);

        // Clean sweep: start latency, strobe spacing, sweep length
        c0 = cyc;
        enable = 1'b1;
        waitRefresh(0, BUDGET, at);
        checkOutput("first_refresh_latency", at - (c0 + 1), PER + 1);
        r0 = at;
        for (int g = 1; g < NG; g++) begin
            rprev = at;
            waitRefresh(g, 10, at);
            checkOutput("refresh_spacing", at - rprev, 3);
        end
        waitDone(BUDGET, at);
        checkOutput("sweep_length", at - (r0 - 1), 24);
        checkOutput("clean_errCount", errCount, 0);

        // Transient error on group 3, healed by its refresh
        tmrErr[3] = 1'b1;
        waitRefresh(3, BUDGET, at);
        tmrErr[3] = 1'b0;
        waitDone(BUDGET, at);
        checkOutput("transient_errCount", errCount, 1);
        checkOutput("transient_errMask", errMask, 8'h08);
        checkOutput("transient_persist", persistMask, 8'h00);

        // Stuck error on group 5 over three sweeps
        clear  = 1'b1;
        tmrErr = 8'h20;
        nextCycle();
        clear = 1'b0;
        for (int s = 0; s < 3; s++) waitDone(BUDGET, at);
        checkOutput("stuck_errCount", errCount, 3);
        checkOutput("stuck_errMask", errMask, 8'h20);
        checkOutput("stuck_persist", persistMask, 8'h20);

        // Short busy on group 2 delays its strobe by two cycles
        tmrErr = '0;
        clear  = 1'b1;
        nextCycle();
        clear = 1'b0;
        waitRefresh(1, BUDGET, r1);
        busyProbe(2, 2, vec, at);
        checkOutput("short_busy_target", vec, 8'h04);
        checkOutput("short_busy_delay", at - r1, 5);
        waitDone(BUDGET, at);
        checkOutput("short_busy_skip", skipMask, 8'h00);

        // Long busy on group 2 exhausts the deferral and skips to group 3
        waitRefresh(1, BUDGET, r1);
        busyProbe(2, 10, vec, at);
        checkOutput("long_busy_next", vec, 8'h08);
        checkOutput("long_busy_timing", at - r1, 8);
        checkOutput("long_busy_skip", skipMask, 8'h04);
        waitDone(BUDGET, at);

        // Saturation, then clear coinciding with a fresh error via forceSweep
        clear  = 1'b1;
        tmrErr = '1;
        nextCycle();
        clear = 1'b0;
        waitDone(BUDGET, at);
        waitDone(BUDGET, at);
        checkOutput("sat_errCount", errCount, CMAX);
        checkOutput("sat_persist", persistMask, 8'hFF);
        tmrErr = 8'h01;
        nextCycle();
        forceSweep = 1'b1;
        nextCycle();
        forceSweep = 1'b0;
        clear      = 1'b1;
        nextCycle();
        clear = 1'b0;
        checkOutput("clear_plus_err_count", errCount, 1);
        checkOutput("clear_plus_err_mask", errMask, 8'h01);
        checkOutput("forced_refresh", refresh, 8'h01);
        tmrErr = '0;

        // Async reset during the strobe of group 4, then a full restart
        waitRefresh(4, BUDGET, at);
        #1 rst = 1'b1;
        #1;
        checkOutput("async_rst_refresh", refresh, 0);
        checkOutput("async_rst_errCount", errCount, 0);
        checkOutput("async_rst_errMask", errMask, 0);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        c0  = cyc;
        waitRefresh(0, BUDGET, at);
        checkOutput("restart_latency", at - (c0 + 1), PER + 1);

        for (int n = 0; n < 3000; n++) applyStimulus();
        nextCycle();
        rst = 1'b0;
        repeat (4) nextCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
